// File: rtl/alu_core.sv
// alu_core: 8-bit command ALU (add/and/xor single-cycle, multi-cycle mul) with start/done handshake.
// Optional feature macro: ALU_ILLEGAL_OP_ERR_EN adds an err output that flags illegal opcodes.
module alu_core #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
`ifdef ALU_ILLEGAL_OP_ERR_EN
  output logic        err,
`endif
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  // Counter reloads with latency-1 so the completing edge is capture+MUL_LATENCY.
  localparam logic [2:0] CNT_LOAD = 3'(MUL_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [2:0]  r_op;
  logic        r_arm;
  logic [2:0]  r_cnt;
  logic        r_done;
  logic [15:0] r_result;
  logic [7:0]  w_a_nxt;
  logic [7:0]  w_b_nxt;
  logic [2:0]  w_op_nxt;
  logic        w_arm_nxt;
  logic [2:0]  w_cnt_nxt;
  logic        w_done_nxt;
  logic [15:0] w_result_nxt;
  logic        w_capture;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic        r_err;
  logic        w_err_nxt;
`endif

  function automatic logic [15:0] alu_eval(input logic [2:0] f_op,
                                           input logic [7:0] f_a,
                                           input logic [7:0] f_b);
    logic [15:0] v;
    case (f_op)
      OP_ADD:  v = {7'b0000000, {1'b0, f_a} + {1'b0, f_b}};
      OP_AND:  v = {8'h00, f_a & f_b};
      OP_XOR:  v = {8'h00, f_a ^ f_b};
      OP_MUL:  v = {8'h00, f_a} * {8'h00, f_b};
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

`ifdef ALU_ILLEGAL_OP_ERR_EN
  function automatic logic is_illegal(input logic [2:0] f_op);
    return f_op[2] & (f_op[1:0] != 2'b00);
  endfunction
`endif

  // Next-state, handshake and datapath decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_arm_nxt    = r_arm | ~start;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_capture    = 1'b0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
    w_err_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start && r_arm) begin
          w_capture = 1'b1;
          case (op)
            OP_NOP: begin
              w_state_nxt = S_IDLE;
            end
            OP_ADD, OP_AND, OP_XOR: begin
              w_state_nxt = S_EXEC;
              w_arm_nxt   = 1'b0;
            end
            OP_MUL: begin
              w_state_nxt = S_MUL;
              w_arm_nxt   = 1'b0;
              w_cnt_nxt   = CNT_LOAD;
            end
            default: begin
`ifdef ALU_ILLEGAL_OP_ERR_EN
              w_state_nxt = S_EXEC;
              w_arm_nxt   = 1'b0;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          endcase
        end else begin
          w_capture = 1'b0;
        end
      end
      S_EXEC: begin
        w_state_nxt  = S_DONE;
        w_done_nxt   = 1'b1;
        w_result_nxt = alu_eval(r_op, r_a, r_b);
`ifdef ALU_ILLEGAL_OP_ERR_EN
        w_err_nxt    = is_illegal(r_op);
`endif
      end
      S_MUL: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt  = S_DONE;
          w_done_nxt   = 1'b1;
          w_result_nxt = alu_eval(OP_MUL, r_a, r_b);
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_capture) begin
      w_a_nxt  = A;
      w_b_nxt  = B;
      w_op_nxt = op;
    end else begin
      w_a_nxt  = w_a_nxt;
    end
  end

  // State register; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand, handshake and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_op     <= 3'b000;
      r_arm    <= 1'b1;
      r_cnt    <= 3'd0;
      r_done   <= 1'b0;
      r_result <= 16'h0000;
`ifdef ALU_ILLEGAL_OP_ERR_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_arm    <= w_arm_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
`ifdef ALU_ILLEGAL_OP_ERR_EN
      r_err    <= w_err_nxt;
`endif
    end
  end

  assign done   = r_done;
  assign result = r_result;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  assign err    = r_err;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (MUL_LATENCY=3); follows ALU_ILLEGAL_OP_ERR_EN if defined.
module tb_alu_core;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic        err;
`endif
  int          vectors;
  int          miscompares;

  alu_core #(.MUL_LATENCY(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
`ifdef ALU_ILLEGAL_OP_ERR_EN
    .err     (err),
`endif
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; A = 8'h00; B = 8'h00;
    tick(); tick();
    check("rst_done", {15'd0, done}, 16'h0000);
    check("rst_result", result, 16'h0000);

    // add FF+01 on the first posedge out of reset, start held throughout
    reset_n = 1'b1; start = 1'b1; op = 3'b001; A = 8'hFF; B = 8'h01;
    tick();
    check("add_cap_done", {15'd0, done}, 16'h0000);
    A = 8'h55; B = 8'h66; op = 3'b100;
    tick();
    check("add_done", {15'd0, done}, 16'h0001);
    check("add_result", result, 16'h0100);
    tick();
    check("add_pulse_end", {15'd0, done}, 16'h0000);
    check("add_hold", result, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_retrigger", {15'd0, done}, 16'h0000);
    end

    // drop start one cycle, then xor F0^3C
    start = 1'b0;
    tick();
    start = 1'b1; op = 3'b011; A = 8'hF0; B = 8'h3C;
    tick();
    check("xor_cap_done", {15'd0, done}, 16'h0000);
    tick();
    check("xor_done", {15'd0, done}, 16'h0001);
    check("xor_result", result, 16'h00CC);
    tick();
    check("xor_pulse_end", {15'd0, done}, 16'h0000);
    start = 1'b0;
    tick();

    // and F0&3C, start dropped during EXEC
    start = 1'b1; op = 3'b010; A = 8'hF0; B = 8'h3C;
    tick();
    start = 1'b0;
    tick();
    check("and_done", {15'd0, done}, 16'h0001);
    check("and_result", result, 16'h0030);
    tick();
    check("and_pulse_end", {15'd0, done}, 16'h0000);

    // mul FF*FF, done at capture+3, start held
    start = 1'b1; op = 3'b100; A = 8'hFF; B = 8'hFF;
    tick();
    check("mul_c0_done", {15'd0, done}, 16'h0000);
    tick();
    check("mul_c1_done", {15'd0, done}, 16'h0000);
    check("mul_c1_result", result, 16'h0030);
    tick();
    check("mul_c2_done", {15'd0, done}, 16'h0000);
    check("mul_c2_result", result, 16'h0030);
    tick();
    check("mul_done", {15'd0, done}, 16'h0001);
    check("mul_result", result, 16'hFE01);
    tick();
    check("mul_pulse_end", {15'd0, done}, 16'h0000);
    check("mul_hold", result, 16'hFE01);
    start = 1'b0;
    tick();

    // reset at capture+1 of a mul aborts it
    start = 1'b1; op = 3'b100; A = 8'h12; B = 8'h34;
    tick();
    reset_n = 1'b0;
    tick();
    check("abort_rst_done", {15'd0, done}, 16'h0000);
    check("abort_rst_result", result, 16'h0000);
    reset_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done", {15'd0, done}, 16'h0000);
      check("abort_result", result, 16'h0000);
    end
    start = 1'b1; op = 3'b001; A = 8'h02; B = 8'h03;
    tick();
    tick();
    check("post_rst_add_done", {15'd0, done}, 16'h0001);
    check("post_rst_add_result", result, 16'h0005);
    tick();
    start = 1'b0;
    tick();

    // no_op for one cycle, then add 10+20 without dropping start
    start = 1'b1; op = 3'b000; A = 8'h77; B = 8'h88;
    tick();
    check("nop_done", {15'd0, done}, 16'h0000);
    op = 3'b001; A = 8'h10; B = 8'h20;
    tick();
    check("nop_add_cap_done", {15'd0, done}, 16'h0000);
    check("nop_result_hold", result, 16'h0005);
    tick();
    check("nop_add_done", {15'd0, done}, 16'h0001);
    check("nop_add_result", result, 16'h0030);
    tick();
    start = 1'b0;
    tick();

    // illegal opcode 111
    start = 1'b1; op = 3'b111; A = 8'hAA; B = 8'h55;
    tick();
    check("ill_cap_done", {15'd0, done}, 16'h0000);
    tick();
`ifdef ALU_ILLEGAL_OP_ERR_EN
    check("ill_done", {15'd0, done}, 16'h0001);
    check("ill_err", {15'd0, err}, 16'h0001);
    check("ill_result", result, 16'h0000);
    tick();
    check("ill_pulse_end", {15'd0, done}, 16'h0000);
    check("ill_err_end", {15'd0, err}, 16'h0000);
`else
    check("ill_no_done", {15'd0, done}, 16'h0000);
    check("ill_result_hold", result, 16'h0030);
    tick();
    check("ill_no_done2", {15'd0, done}, 16'h0000);
`endif
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
